// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the aq_djpeg MCU scheduling path: FSM encoding,
// MCU geometry constants and the shift-based MCU grid helpers.
package aq_djpeg_pkg;

  localparam int MCU_W1 = 32;
  localparam int MCU_H1 = 8;
  localparam int BLK    = 8;
  localparam int IDX_W  = 12;

  localparam logic [2:0] SH_W1  = 3'($clog2(MCU_W1));
  localparam logic [2:0] SH_H1  = 3'($clog2(MCU_H1));
  localparam logic [2:0] SH_BLK = 3'($clog2(BLK));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only factors 1 and 2 give power-of-two MCU sizes; 0 acts as 1 and 3 as 2.
  function automatic logic [2:0] sub_shift(input logic [1:0] sub);
    return (sub >= 2'd2) ? (SH_BLK + 3'd1) : SH_BLK;
  endfunction

  // ceil(dim / 2^shift), saturated to the largest 12-bit MCU count.
  function automatic logic [IDX_W-1:0] mcu_count(input logic [15:0] dim,
                                                 input logic [2:0]  shift);
    logic [16:0] sum;
    logic [16:0] q;
    sum = {1'b0, dim} + ((17'd1 << shift) - 17'd1);
    q   = sum >> shift;
    return (|q[16:IDX_W]) ? {IDX_W{1'b1}} : q[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/aq_djpeg_mcu_counter.sv
// Raster-order MCU position counter: X wraps at cols_m1 and carries into Y,
// which itself wraps after the last row.
module aq_djpeg_mcu_counter
  import aq_djpeg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W-1:0] cols_m1,
  input  logic [IDX_W-1:0] rows_m1,
  output logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] y,
  output logic             last
);

  logic [IDX_W-1:0] x_q, x_d;
  logic [IDX_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == cols_m1) begin
        x_d = '0;
        y_d = (y_q == rows_m1) ? '0 : y_q + 12'd1;
      end else begin
        x_d = x_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == cols_m1) && (y_q == rows_m1);

endmodule

// File: rtl/aq_djpeg_mcu_scheduler.sv
// Ping-pong bank scheduler between the MCU writer and the colour converter:
// tracks two bank-full flags, both MCU positions and the frame FSM.
module aq_djpeg_mcu_scheduler
  import aq_djpeg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             FrameStart,
  input  logic [15:0]      ImageWidth,
  input  logic [15:0]      ImageHeight,
  input  logic [2:0]       CompNum,
  input  logic [1:0]       SubSamplingW,
  input  logic [1:0]       SubSamplingH,
  output logic             WrReady,
  output logic             WrBank,
  input  logic             WrDone,
  output logic             ConvEnable,
  output logic             ConvBank,
  output logic [IDX_W-1:0] ConvBlockX,
  output logic [IDX_W-1:0] ConvBlockY,
  output logic [2:0]       ConvComp,
  output logic [1:0]       ConvSubW,
  output logic [1:0]       ConvSubH,
  input  logic             ConvReadNext,
  output logic             Busy,
  output logic             FrameDone
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cols_m1_q, cols_m1_d, rows_m1_q, rows_m1_d;
  logic             zero_q, zero_d;
  logic [2:0]       comp_q, comp_d;
  logic [1:0]       subw_q, subw_d, subh_q, subh_d;
  logic [1:0]       full_q, full_d;
  logic             wptr_q, wptr_d, rptr_q, rptr_d;
  logic             conv_active_q, conv_active_d;
  logic             wr_all_q, wr_all_d;
  logic             conv_en_q, conv_en_d;
  logic             conv_bank_q, conv_bank_d;
  logic [IDX_W-1:0] conv_x_q, conv_x_d, conv_y_q, conv_y_d;
  logic [2:0]       conv_comp_q, conv_comp_d;
  logic [1:0]       conv_subw_q, conv_subw_d, conv_subh_q, conv_subh_d;

  logic [2:0]       w_shift, h_shift;
  logic [IDX_W-1:0] cols, rows;
  logic             start_acc, wr_ready, wr_acc, rd_acc, en_cond;
  logic [IDX_W-1:0] wr_x, wr_y, rd_x, rd_y;
  logic             wr_last, rd_last;

  always_comb begin
    w_shift   = (CompNum == 3'd1) ? SH_W1 : sub_shift(SubSamplingW);
    h_shift   = (CompNum == 3'd1) ? SH_H1 : sub_shift(SubSamplingH);
    cols      = mcu_count(ImageWidth, w_shift);
    rows      = mcu_count(ImageHeight, h_shift);
    start_acc = (state_q == ST_IDLE) && FrameStart;
    wr_ready  = (state_q == ST_RUN) && !full_q[wptr_q] && !wr_all_q;
    wr_acc    = WrDone && wr_ready;
    rd_acc    = ConvReadNext && conv_active_q;
    en_cond   = (state_q == ST_RUN) && full_q[rptr_q] && !conv_active_q;
  end

  always_comb begin
    state_d       = state_q;
    cols_m1_d     = cols_m1_q;
    rows_m1_d     = rows_m1_q;
    zero_d        = zero_q;
    comp_d        = comp_q;
    subw_d        = subw_q;
    subh_d        = subh_q;
    full_d        = full_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    conv_active_d = conv_active_q;
    wr_all_d      = wr_all_q;
    conv_en_d     = 1'b0;
    conv_bank_d   = conv_bank_q;
    conv_x_d      = conv_x_q;
    conv_y_d      = conv_y_q;
    conv_comp_d   = conv_comp_q;
    conv_subw_d   = conv_subw_q;
    conv_subh_d   = conv_subh_q;
    case (state_q)
      ST_IDLE: begin
        if (FrameStart) begin
          state_d       = ST_RUN;
          cols_m1_d     = cols - 12'd1;
          rows_m1_d     = rows - 12'd1;
          zero_d        = (cols == '0) || (rows == '0);
          wr_all_d      = (cols == '0) || (rows == '0);
          comp_d        = CompNum;
          subw_d        = SubSamplingW;
          subh_d        = SubSamplingH;
          full_d        = 2'b00;
          wptr_d        = 1'b0;
          rptr_d        = 1'b0;
          conv_active_d = 1'b0;
        end
      end
      ST_RUN: begin
        // An empty frame spends one cycle here with the writer blocked.
        if (zero_q) state_d = ST_DONE;
        if (rd_acc) begin
          full_d[rptr_q] = 1'b0;
          rptr_d         = ~rptr_q;
          conv_active_d  = 1'b0;
          if (rd_last) state_d = ST_DONE;
        end
        if (wr_acc) begin
          full_d[wptr_q] = 1'b1;
          wptr_d         = ~wptr_q;
          if (wr_last) wr_all_d = 1'b1;
        end
        if (en_cond) begin
          conv_en_d     = 1'b1;
          conv_active_d = 1'b1;
          conv_bank_d   = rptr_q;
          conv_x_d      = rd_x;
          conv_y_d      = rd_y;
          conv_comp_d   = comp_q;
          conv_subw_d   = subw_q;
          conv_subh_d   = subh_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cols_m1_q     <= '0;
      rows_m1_q     <= '0;
      zero_q        <= 1'b0;
      comp_q        <= '0;
      subw_q        <= '0;
      subh_q        <= '0;
      full_q        <= 2'b00;
      wptr_q        <= 1'b0;
      rptr_q        <= 1'b0;
      conv_active_q <= 1'b0;
      wr_all_q      <= 1'b0;
      conv_en_q     <= 1'b0;
      conv_bank_q   <= 1'b0;
      conv_x_q      <= '0;
      conv_y_q      <= '0;
      conv_comp_q   <= '0;
      conv_subw_q   <= '0;
      conv_subh_q   <= '0;
    end else begin
      state_q       <= state_d;
      cols_m1_q     <= cols_m1_d;
      rows_m1_q     <= rows_m1_d;
      zero_q        <= zero_d;
      comp_q        <= comp_d;
      subw_q        <= subw_d;
      subh_q        <= subh_d;
      full_q        <= full_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      conv_active_q <= conv_active_d;
      wr_all_q      <= wr_all_d;
      conv_en_q     <= conv_en_d;
      conv_bank_q   <= conv_bank_d;
      conv_x_q      <= conv_x_d;
      conv_y_q      <= conv_y_d;
      conv_comp_q   <= conv_comp_d;
      conv_subw_q   <= conv_subw_d;
      conv_subh_q   <= conv_subh_d;
    end
  end

  // With no bank in flight the writer and reader must sit on the same MCU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_acc && rd_acc && (wptr_q == rptr_q)));
      assert ((full_q != 2'b00) || ((wr_x == rd_x) && (wr_y == rd_y)));
    end
  end

  aq_djpeg_mcu_counter u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .advance (wr_acc),
    .cols_m1 (cols_m1_q),
    .rows_m1 (rows_m1_q),
    .x       (wr_x),
    .y       (wr_y),
    .last    (wr_last)
  );

  aq_djpeg_mcu_counter u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .advance (rd_acc),
    .cols_m1 (cols_m1_q),
    .rows_m1 (rows_m1_q),
    .x       (rd_x),
    .y       (rd_y),
    .last    (rd_last)
  );

  assign WrReady    = wr_ready;
  assign WrBank     = wptr_q;
  assign ConvEnable = conv_en_q;
  assign ConvBank   = conv_bank_q;
  assign ConvBlockX = conv_x_q;
  assign ConvBlockY = conv_y_q;
  assign ConvComp   = conv_comp_q;
  assign ConvSubW   = conv_subw_q;
  assign ConvSubH   = conv_subh_q;
  assign Busy       = (state_q != ST_IDLE);
  assign FrameDone  = (state_q == ST_DONE);

endmodule

// File: tb/tb_aq_djpeg_mcu_scheduler.sv
// Self-checking bench for aq_djpeg_mcu_scheduler: table-driven frames with a
// writer/converter model and scoreboard, plus hand-built corner sequences.
module tb_aq_djpeg_mcu_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        FrameStart;
  logic [15:0] ImageWidth, ImageHeight;
  logic [2:0]  CompNum;
  logic [1:0]  SubSamplingW, SubSamplingH;
  logic        WrReady, WrBank, WrDone;
  logic        ConvEnable, ConvBank, ConvReadNext;
  logic [11:0] ConvBlockX, ConvBlockY;
  logic [2:0]  ConvComp;
  logic [1:0]  ConvSubW, ConvSubH;
  logic        Busy, FrameDone;

  always #5 clk = ~clk;

  aq_djpeg_mcu_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .FrameStart   (FrameStart),
    .ImageWidth   (ImageWidth),
    .ImageHeight  (ImageHeight),
    .CompNum      (CompNum),
    .SubSamplingW (SubSamplingW),
    .SubSamplingH (SubSamplingH),
    .WrReady      (WrReady),
    .WrBank       (WrBank),
    .WrDone       (WrDone),
    .ConvEnable   (ConvEnable),
    .ConvBank     (ConvBank),
    .ConvBlockX   (ConvBlockX),
    .ConvBlockY   (ConvBlockY),
    .ConvComp     (ConvComp),
    .ConvSubW     (ConvSubW),
    .ConvSubH     (ConvSubH),
    .ConvReadNext (ConvReadNext),
    .Busy         (Busy),
    .FrameDone    (FrameDone)
  );

  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    logic [2:0]  comp;
    logic [1:0]  subw;
    logic [1:0]  subh;
    int          expCols;
    int          expRows;
    int          convDelay;
  } frame_vec_t;

  typedef struct {
    int x;
    int y;
    int bank;
    int comp;
    int subw;
    int subh;
  } mcu_exp_t;

  mcu_exp_t   sbQ[$];
  frame_vec_t vecs[7];
  int         checkCount = 0;
  int         passCount  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input frame_vec_t v);
    FrameStart   = 1'b1;
    ImageWidth   = v.w;
    ImageHeight  = v.h;
    CompNum      = v.comp;
    SubSamplingW = v.subw;
    SubSamplingH = v.subh;
    tick;
    FrameStart   = 1'b0;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, " WrReady"}, int'(WrReady), 0);
    checkOutput({name, " ConvEnable"}, int'(ConvEnable), 0);
    checkOutput({name, " Busy"}, int'(Busy), 0);
    checkOutput({name, " FrameDone"}, int'(FrameDone), 0);
    checkOutput({name, " other outputs"},
                int'({WrBank, ConvBank, ConvBlockX, ConvBlockY, ConvComp, ConvSubW, ConvSubH} != 0), 0);
  endtask

  // Writer always ready; converter answers convDelay cycles after each enable.
  task automatic runFrame(input frame_vec_t v);
    int total, writes, enables, dones, post, cyc, cnt, lastRn, wx, wy, readyAfterLast;
    bit convBusy;
    mcu_exp_t cur, e;
    total = v.expCols * v.expRows;
    writes = 0; enables = 0; dones = 0; post = 0; cyc = 0; cnt = 0;
    lastRn = -10; wx = 0; wy = 0; readyAfterLast = 0; convBusy = 1'b0;
    cur = '{x: 0, y: 0, bank: 0, comp: 0, subw: 0, subh: 0};
    sbQ.delete();
    applyStimulus(v);
    while (cyc < 3000 && post < 3) begin
      WrDone = 1'b0;
      ConvReadNext = 1'b0;
      if (ConvEnable) begin
        checkOutput("enable while converter busy", int'(convBusy), 0);
        checkOutput("gap ReadNext->ConvEnable ok", int'(cyc - lastRn >= 2), 1);
        if (sbQ.size() == 0) begin
          checkOutput("ConvEnable with nothing written", 1, 0);
        end else begin
          cur = sbQ.pop_front();
          checkOutput("ConvBlockX", int'(ConvBlockX), cur.x);
          checkOutput("ConvBlockY", int'(ConvBlockY), cur.y);
          checkOutput("ConvBank", int'(ConvBank), cur.bank);
          checkOutput("ConvComp", int'(ConvComp), cur.comp);
          checkOutput("ConvSubW", int'(ConvSubW), cur.subw);
          checkOutput("ConvSubH", int'(ConvSubH), cur.subh);
        end
        enables++;
        convBusy = 1'b1;
        cnt = v.convDelay;
      end
      if (convBusy) begin
        if (cnt == 0) begin
          checkOutput("ConvBlockX held", int'(ConvBlockX), cur.x);
          checkOutput("ConvBlockY held", int'(ConvBlockY), cur.y);
          ConvReadNext = 1'b1;
          convBusy = 1'b0;
          lastRn = cyc;
        end else begin
          cnt--;
        end
      end
      if (WrReady) begin
        if (writes >= total) begin
          readyAfterLast++;
        end else begin
          checkOutput("WrBank", int'(WrBank), writes % 2);
          WrDone = 1'b1;
          e = '{x: wx, y: wy, bank: writes % 2, comp: int'(v.comp),
                subw: int'(v.subw), subh: int'(v.subh)};
          sbQ.push_back(e);
          writes++;
          if (wx == v.expCols - 1) begin
            wx = 0;
            wy++;
          end else begin
            wx++;
          end
        end
      end
      if (FrameDone) dones++;
      if (dones > 0) post++;
      tick;
      cyc++;
    end
    WrDone = 1'b0;
    ConvReadNext = 1'b0;
    checkOutput("frame finished within budget", int'(cyc < 3000), 1);
    checkOutput("ConvEnable pulse count", enables, total);
    checkOutput("writes accepted", writes, total);
    checkOutput("FrameDone pulse count", dones, 1);
    checkOutput("WrReady after last write", readyAfterLast, 0);
    checkOutput("scoreboard empty", sbQ.size(), 0);
    checkOutput("Busy after frame", int'(Busy), 0);
  endtask

  initial begin
    rst = 1'b1; FrameStart = 1'b0; ImageWidth = '0; ImageHeight = '0;
    CompNum = '0; SubSamplingW = '0; SubSamplingH = '0;
    WrDone = 1'b0; ConvReadNext = 1'b0;

    vecs[0] = '{w: 16'd64,  h: 16'd16, comp: 3'd3, subw: 2'd2, subh: 2'd2, expCols: 4, expRows: 1, convDelay: 10};
    vecs[1] = '{w: 16'd100, h: 16'd8,  comp: 3'd1, subw: 2'd0, subh: 2'd0, expCols: 4, expRows: 1, convDelay: 2};
    vecs[2] = '{w: 16'd17,  h: 16'd9,  comp: 3'd3, subw: 2'd1, subh: 2'd1, expCols: 3, expRows: 2, convDelay: 0};
    vecs[3] = '{w: 16'd33,  h: 16'd17, comp: 3'd3, subw: 2'd2, subh: 2'd1, expCols: 3, expRows: 3, convDelay: 5};
    vecs[4] = '{w: 16'd32,  h: 16'd32, comp: 3'd3, subw: 2'd2, subh: 2'd2, expCols: 2, expRows: 2, convDelay: 3};
    vecs[5] = '{w: 16'd1,   h: 16'd1,  comp: 3'd1, subw: 2'd0, subh: 2'd0, expCols: 1, expRows: 1, convDelay: 1};
    vecs[6] = '{w: 16'd16,  h: 16'd8,  comp: 3'd3, subw: 2'd2, subh: 2'd1, expCols: 1, expRows: 1, convDelay: 4};

    tick; tick;
    checkResetOutputs("reset");
    rst = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] frame vector %0d: %0dx%0d comp %0d", i, vecs[i].w, vecs[i].h, vecs[i].comp);
      runFrame(vecs[i]);
    end

    // Converter stall with both banks full, then reset mid-frame.
    applyStimulus('{w: 16'd96, h: 16'd8, comp: 3'd1, subw: 2'd0, subh: 2'd0, expCols: 3, expRows: 1, convDelay: 0});
    checkOutput("stall WrReady first", int'(WrReady), 1);
    checkOutput("stall WrBank first", int'(WrBank), 0);
    WrDone = 1'b1;
    tick;
    checkOutput("stall WrReady second", int'(WrReady), 1);
    checkOutput("stall WrBank second", int'(WrBank), 1);
    checkOutput("stall no early enable", int'(ConvEnable), 0);
    tick;
    checkOutput("both full WrReady", int'(WrReady), 0);
    checkOutput("enable latency", int'(ConvEnable), 1);
    checkOutput("enable bank 0", int'(ConvBank), 0);
    tick;
    checkOutput("enable single pulse", int'(ConvEnable), 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stalled WrReady", int'(WrReady), 0);
      tick;
    end
    WrDone = 1'b0;
    ConvReadNext = 1'b1;
    tick;
    ConvReadNext = 1'b0;
    checkOutput("WrReady after ReadNext", int'(WrReady), 1);
    checkOutput("WrBank after ReadNext", int'(WrBank), 0);
    checkOutput("no enable right after ReadNext", int'(ConvEnable), 0);
    tick;
    checkOutput("second enable", int'(ConvEnable), 1);
    checkOutput("second enable bank", int'(ConvBank), 1);
    checkOutput("second enable X", int'(ConvBlockX), 1);
    rst = 1'b1;
    tick;
    checkResetOutputs("mid-frame reset");
    rst = 1'b0;
    runFrame(vecs[6]);

    // Same-cycle write and read on opposite banks, and an ignored FrameStart.
    applyStimulus('{w: 16'd96, h: 16'd8, comp: 3'd1, subw: 2'd0, subh: 2'd0, expCols: 3, expRows: 1, convDelay: 0});
    WrDone = 1'b1;
    tick;
    WrDone = 1'b0;
    tick;
    checkOutput("overlap enable bank0", int'(ConvEnable), 1);
    checkOutput("overlap WrBank", int'(WrBank), 1);
    WrDone = 1'b1;
    ConvReadNext = 1'b1;
    tick;
    WrDone = 1'b0;
    ConvReadNext = 1'b0;
    checkOutput("overlap WrReady", int'(WrReady), 1);
    checkOutput("overlap WrBank after", int'(WrBank), 0);
    checkOutput("overlap no enable yet", int'(ConvEnable), 0);
    tick;
    checkOutput("overlap enable bank1", int'(ConvEnable), 1);
    checkOutput("overlap ConvBank", int'(ConvBank), 1);
    FrameStart = 1'b1; ImageWidth = 16'd0; CompNum = 3'd3;
    WrDone = 1'b1;
    ConvReadNext = 1'b1;
    tick;
    FrameStart = 1'b0; WrDone = 1'b0; ConvReadNext = 1'b0;
    checkOutput("ignored start WrReady", int'(WrReady), 0);
    checkOutput("ignored start Busy", int'(Busy), 1);
    checkOutput("ignored start FrameDone", int'(FrameDone), 0);
    tick;
    checkOutput("last enable", int'(ConvEnable), 1);
    checkOutput("last ConvBank", int'(ConvBank), 0);
    checkOutput("last ConvBlockX", int'(ConvBlockX), 2);
    checkOutput("config held ConvComp", int'(ConvComp), 1);
    ConvReadNext = 1'b1;
    tick;
    ConvReadNext = 1'b0;
    checkOutput("overlap FrameDone", int'(FrameDone), 1);
    tick;
    checkOutput("overlap FrameDone drop", int'(FrameDone), 0);
    checkOutput("overlap Busy drop", int'(Busy), 0);

    // Empty frames: zero width, then zero height.
    for (int z = 0; z < 2; z++) begin
      applyStimulus('{w: (z == 0) ? 16'd0 : 16'd40, h: (z == 0) ? 16'd8 : 16'd0, comp: 3'd1,
                      subw: 2'd0, subh: 2'd0, expCols: 0, expRows: 0, convDelay: 0});
      checkOutput("empty frame FrameDone early", int'(FrameDone), 0);
      checkOutput("empty frame WrReady", int'(WrReady), 0);
      checkOutput("empty frame enable early", int'(ConvEnable), 0);
      tick;
      checkOutput("empty frame FrameDone", int'(FrameDone), 1);
      checkOutput("empty frame enable", int'(ConvEnable), 0);
      tick;
      checkOutput("empty frame FrameDone drop", int'(FrameDone), 0);
      checkOutput("empty frame Busy drop", int'(Busy), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
